// File: rtl/sobel_pkg.sv
// Shared types for the Sobel window controller: pixel/window types and FSM state encoding.
package sobel_pkg;

    localparam int PIX_W = 8;

    typedef logic [PIX_W-1:0] pixel_t;
    typedef pixel_t window_t [0:8];

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } ctrl_state_t;

endpackage

// File: rtl/sobel_line_buffer.sv
// One-row line buffer: single address, asynchronous read, so the old word is seen before the write lands.
module sobel_line_buffer #(
    parameter int DEPTH  = 640,
    parameter int WIDTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/sobel_window_ctrl.sv
// Raster pixel stream -> interior 3x3 windows with valid/ready; window bus packs P0 in the low bits.
// Optional `SOBEL_CTRL_STALL_CNT_EN adds a saturating stall_cycles counter output.
module sobel_window_ctrl #(
    parameter int  IMG_WIDTH  = 640,
    parameter int  IMG_HEIGHT = 480,
    parameter int  PIX_W      = 8,
    localparam int COL_W      = $clog2(IMG_WIDTH),
    localparam int ROW_W      = $clog2(IMG_HEIGHT)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_start,
    input  logic               pix_valid,
    input  logic [PIX_W-1:0]   pix_data,
    output logic               pix_ready,
    output logic               win_valid,
    input  logic               win_ready,
    output logic [9*PIX_W-1:0] window,
    output logic [COL_W-1:0]   win_col,
    output logic [ROW_W-1:0]   win_row,
    output logic               frame_done,
    output logic               busy
`ifdef SOBEL_CTRL_STALL_CNT_EN
    ,
    output logic [15:0]        stall_cycles
`endif
);

    import sobel_pkg::*;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

    ctrl_state_t      state;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             accept;
    logic             load;
    logic [PIX_W-1:0] lb0_rd;
    logic [PIX_W-1:0] lb1_rd;
    logic [PIX_W-1:0] win_sr [0:8];

    assign pix_ready = (state == RUN) && (!win_valid || win_ready);
    assign accept    = pix_valid && pix_ready;
    assign load      = accept && (row >= ROW_W'(2)) && (col >= COL_W'(2));
    assign busy      = (state != IDLE);

    // Both line buffers share one address, so they live in a single double-width memory.
    sobel_line_buffer #(
        .DEPTH (IMG_WIDTH),
        .WIDTH (2 * PIX_W)
    ) u_line_buf (
        .clk   (clk),
        .we    (accept),
        .addr  (col),
        .wdata ({lb0_rd, pix_data}),
        .rdata ({lb1_rd, lb0_rd})
    );

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int unsigned r = 0; r < 3; r++) begin
                win_sr[3*r]   <= win_sr[3*r+1];
                win_sr[3*r+1] <= win_sr[3*r+2];
            end
            win_sr[2] <= lb1_rd;
            win_sr[5] <= lb0_rd;
            win_sr[8] <= pix_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            col        <= '0;
            row        <= '0;
            win_valid  <= 1'b0;
            window     <= '0;
            win_col    <= '0;
            win_row    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;

            if (load) begin
                window  <= {pix_data, win_sr[8], win_sr[7], lb0_rd, win_sr[5],
                            win_sr[4], lb1_rd, win_sr[2], win_sr[1]};
                win_row <= row - ROW_W'(1);
                win_col <= col - COL_W'(1);
                win_valid <= 1'b1;
            end else if (win_ready) begin
                win_valid <= 1'b0;
            end

            if (accept) begin
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= row + ROW_W'(1);
                end else begin
                    col <= col + COL_W'(1);
                end
            end

            unique case (state)
                IDLE: begin
                    if (frame_start) begin
                        state <= RUN;
                        col   <= '0;
                        row   <= '0;
                    end
                end
                RUN: begin
                    if (accept && row == ROW_LAST && col == COL_LAST) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!win_valid || win_ready) begin
                        frame_done <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SOBEL_CTRL_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (state == IDLE && frame_start) begin
            stall_cycles <= '0;
        end else if (win_valid && !win_ready && stall_cycles != '1) begin
            stall_cycles <= stall_cycles + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Directed bench for sobel_window_ctrl: 5x4 frames (basic, back-pressure, stray frame_start,
// mid-frame reset, gapped input) plus a 3x3 frame on a second instance.
module tb_sobel_window_ctrl;

    localparam int W  = 5;
    localparam int H  = 4;
    localparam int PW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst, frame_start, pix_valid, win_ready;
    logic [PW-1:0]   pix_data;
    logic            pix_ready, win_valid, frame_done, busy;
    logic [9*PW-1:0] window;
    logic [2:0]      win_col;
    logic [1:0]      win_row;
`ifdef SOBEL_CTRL_STALL_CNT_EN
    logic [15:0]     stall_cycles;
`endif

    logic            b_frame_start, b_pix_valid, b_win_ready;
    logic [PW-1:0]   b_pix_data;
    logic            b_pix_ready, b_win_valid, b_frame_done, b_busy;
    logic [9*PW-1:0] b_window;
    logic [1:0]      b_win_col, b_win_row;
`ifdef SOBEL_CTRL_STALL_CNT_EN
    logic [15:0]     b_stall_cycles;
`endif

    sobel_window_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(PW)) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .pix_valid(pix_valid),
        .pix_data(pix_data), .pix_ready(pix_ready), .win_valid(win_valid),
        .win_ready(win_ready), .window(window), .win_col(win_col), .win_row(win_row),
        .frame_done(frame_done), .busy(busy)
`ifdef SOBEL_CTRL_STALL_CNT_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    sobel_window_ctrl #(.IMG_WIDTH(3), .IMG_HEIGHT(3), .PIX_W(PW)) dut_3x3 (
        .clk(clk), .rst(rst), .frame_start(b_frame_start), .pix_valid(b_pix_valid),
        .pix_data(b_pix_data), .pix_ready(b_pix_ready), .win_valid(b_win_valid),
        .win_ready(b_win_ready), .window(b_window), .win_col(b_win_col), .win_row(b_win_row),
        .frame_done(b_frame_done), .busy(b_busy)
`ifdef SOBEL_CTRL_STALL_CNT_EN
        , .stall_cycles(b_stall_cycles)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Handshake log for the 5x4 instance; only appended here, read by the tests.
    logic [9*PW-1:0] got_win [$];
    int              got_row [$];
    int              got_col [$];
    int              done_total = 0;

    always @(negedge clk) begin
        if (win_valid && win_ready) begin
            got_win.push_back(window);
            got_row.push_back(int'(win_row));
            got_col.push_back(int'(win_col));
        end
        if (frame_done) done_total++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time exceeded, required completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [9*PW-1:0] exp_window(input int w, input int r, input int c);
        logic [9*PW-1:0] v = '0;
        for (int k = 0; k < 9; k++) v[k*PW +: PW] = PW'((r - 1 + k / 3) * w + (c - 1 + k % 3));
        return v;
    endfunction

    // Drives pixels 0..stop_after-1 (value = index) into the 5x4 instance after arming a frame.
    task automatic run_frame(input bit gap, input bit stall, input bit mid_fs,
                             input int stop_after, output int cycles);
        int base = got_win.size();
        int p = 0;
        int stall_rem = stall ? 4 : 0;
        int stall_idx = 0;
        bit acc;
        logic [9*PW-1:0] held = '0;
        cycles = 0;
        @(posedge clk); #1 frame_start = 1'b1;
        @(posedge clk); #1 frame_start = 1'b0;
        while (p < stop_after && cycles < 500) begin
            pix_valid   = gap ? (cycles % 2 == 0) : 1'b1;
            pix_data    = PW'(p);
            frame_start = mid_fs && (p == 7);
            win_ready   = !(stall && win_valid && (got_win.size() - base) == 1 && stall_rem > 0);
            if (!win_ready) stall_rem--;
            @(negedge clk);
            acc = pix_valid && pix_ready;
            if (!win_ready) begin
                n_checks++;
                if (pix_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stall_pix_ready: got %b, required 0", pix_ready);
                end
                if (stall_idx > 0) begin
                    n_checks++;
                    if (window !== held) begin
                        n_fail++;
                        $display("FAIL stall_window_stable: got %h, required %h", window, held);
                    end
                end else begin
                    held = window;
                end
                stall_idx++;
            end
            @(posedge clk); #1;
            if (acc) p++;
            cycles++;
        end
        pix_valid   = 1'b0;
        frame_start = 1'b0;
        win_ready   = 1'b1;
    endtask

    task automatic wait_done(input int dbase, output int waited);
        waited = -1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk); #1;
            if (done_total > dbase) begin
                waited = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({pix_ready, win_valid, frame_done, busy} !== 4'b0000 || window !== '0 ||
            win_row !== 2'd0 || win_col !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_values: got rdy=%b vld=%b done=%b busy=%b win=%h row=%0d col=%0d, required all 0",
                     pix_ready, win_valid, frame_done, busy, window, win_row, win_col);
        end
        rst = 1'b0;
        pix_valid = 1'b1;
        @(negedge clk);
        n_checks++;
        if (pix_ready !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_no_accept: got rdy=%b busy=%b, required 0 0", pix_ready, busy);
        end
        @(posedge clk); #1 pix_valid = 1'b0;
    endtask

    task automatic test_basic;
        int base = got_win.size();
        int dbase = done_total;
        int cyc, waited, r, c;
        logic [9*PW-1:0] first_exp = {8'd12, 8'd11, 8'd10, 8'd7, 8'd6, 8'd5, 8'd2, 8'd1, 8'd0};
        logic [9*PW-1:0] last_exp  = {8'd19, 8'd18, 8'd17, 8'd14, 8'd13, 8'd12, 8'd9, 8'd8, 8'd7};
        run_frame(1'b0, 1'b0, 1'b0, W * H, cyc);
        n_checks++;
        if (cyc !== W * H) begin
            n_fail++;
            $display("FAIL basic_throughput: got %0d cycles, required %0d", cyc, W * H);
        end
        wait_done(dbase, waited);
        n_checks++;
        if (waited !== 2) begin
            n_fail++;
            $display("FAIL basic_done_timing: got %0d, required 2", waited);
        end
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (done_total - dbase !== 1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done_once: got %0d pulses busy=%b, required 1 pulse busy=0", done_total - dbase, busy);
        end
        n_checks++;
        if (got_win.size() - base !== 6) begin
            n_fail++;
            $display("FAIL basic_count: got %0d windows, required 6", got_win.size() - base);
        end
        if (got_win.size() - base >= 6) begin
            n_checks++;
            if (got_win[base] !== first_exp || got_row[base] !== 1 || got_col[base] !== 1) begin
                n_fail++;
                $display("FAIL basic_first: got %h @(%0d,%0d), required %h @(1,1)",
                         got_win[base], got_row[base], got_col[base], first_exp);
            end
            n_checks++;
            if (got_win[base+5] !== last_exp || got_row[base+5] !== 2 || got_col[base+5] !== 3) begin
                n_fail++;
                $display("FAIL basic_last: got %h @(%0d,%0d), required %h @(2,3)",
                         got_win[base+5], got_row[base+5], got_col[base+5], last_exp);
            end
        end
        for (int k = 0; k < 6 && base + k < got_win.size(); k++) begin
            r = 1 + k / (W - 2);
            c = 1 + k % (W - 2);
            n_checks++;
            if (got_win[base+k] !== exp_window(W, r, c) || got_row[base+k] !== r || got_col[base+k] !== c) begin
                n_fail++;
                $display("FAIL basic_win%0d: got %h @(%0d,%0d), required %h @(%0d,%0d)", k,
                         got_win[base+k], got_row[base+k], got_col[base+k], exp_window(W, r, c), r, c);
            end
        end
    endtask

    task automatic test_backpressure;
        int base = got_win.size();
        int dbase = done_total;
        int cyc, waited, r, c;
        run_frame(1'b0, 1'b1, 1'b0, W * H, cyc);
        wait_done(dbase, waited);
        n_checks++;
        if (waited < 0) begin
            n_fail++;
            $display("FAIL bp_done: got no frame_done, required one pulse");
        end
        n_checks++;
        if (got_win.size() - base !== 6) begin
            n_fail++;
            $display("FAIL bp_count: got %0d windows, required 6", got_win.size() - base);
        end
        for (int k = 0; k < 6 && base + k < got_win.size(); k++) begin
            r = 1 + k / (W - 2);
            c = 1 + k % (W - 2);
            n_checks++;
            if (got_win[base+k] !== exp_window(W, r, c) || got_row[base+k] !== r || got_col[base+k] !== c) begin
                n_fail++;
                $display("FAIL bp_win%0d: got %h @(%0d,%0d), required %h @(%0d,%0d)", k,
                         got_win[base+k], got_row[base+k], got_col[base+k], exp_window(W, r, c), r, c);
            end
        end
`ifdef SOBEL_CTRL_STALL_CNT_EN
        repeat (3) @(negedge clk);
        n_checks++;
        if (stall_cycles !== 16'd4) begin
            n_fail++;
            $display("FAIL bp_stall_cycles: got %0d, required 4", stall_cycles);
        end
`endif
    endtask

    task automatic test_mid_start;
        int base = got_win.size();
        int dbase = done_total;
        int cyc, waited, r, c;
        run_frame(1'b0, 1'b0, 1'b1, W * H, cyc);
        wait_done(dbase, waited);
        n_checks++;
        if (got_win.size() - base !== 6 || waited < 0) begin
            n_fail++;
            $display("FAIL midstart_count: got %0d windows done_wait=%0d, required 6 and a done pulse",
                     got_win.size() - base, waited);
        end
        for (int k = 0; k < 6 && base + k < got_win.size(); k++) begin
            r = 1 + k / (W - 2);
            c = 1 + k % (W - 2);
            n_checks++;
            if (got_win[base+k] !== exp_window(W, r, c) || got_row[base+k] !== r || got_col[base+k] !== c) begin
                n_fail++;
                $display("FAIL midstart_win%0d: got %h @(%0d,%0d), required %h @(%0d,%0d)", k,
                         got_win[base+k], got_row[base+k], got_col[base+k], exp_window(W, r, c), r, c);
            end
        end
    endtask

    task automatic test_reset_midframe;
        int base;
        int dbase;
        int cyc, waited;
        run_frame(1'b0, 1'b0, 1'b0, 10, cyc);
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({pix_ready, win_valid, frame_done, busy} !== 4'b0000 || window !== '0 ||
            win_row !== 2'd0 || win_col !== 3'd0) begin
            n_fail++;
            $display("FAIL midreset_values: got rdy=%b vld=%b done=%b busy=%b win=%h row=%0d col=%0d, required all 0",
                     pix_ready, win_valid, frame_done, busy, window, win_row, win_col);
        end
        rst = 1'b0;
        base  = got_win.size();
        dbase = done_total;
        run_frame(1'b0, 1'b0, 1'b0, W * H, cyc);
        wait_done(dbase, waited);
        n_checks++;
        if (got_win.size() - base !== 6 || waited < 0) begin
            n_fail++;
            $display("FAIL midreset_count: got %0d windows done_wait=%0d, required 6 and a done pulse",
                     got_win.size() - base, waited);
        end
        if (got_win.size() > base) begin
            n_checks++;
            if (got_win[base] !== exp_window(W, 1, 1) || got_row[base] !== 1 || got_col[base] !== 1) begin
                n_fail++;
                $display("FAIL midreset_first: got %h @(%0d,%0d), required %h @(1,1)",
                         got_win[base], got_row[base], got_col[base], exp_window(W, 1, 1));
            end
        end
    endtask

    task automatic test_gapped;
        int base = got_win.size();
        int dbase = done_total;
        int cyc, waited, r, c;
        run_frame(1'b1, 1'b0, 1'b0, W * H, cyc);
        wait_done(dbase, waited);
        n_checks++;
        if (got_win.size() - base !== 6 || waited < 0) begin
            n_fail++;
            $display("FAIL gap_count: got %0d windows done_wait=%0d, required 6 and a done pulse",
                     got_win.size() - base, waited);
        end
        for (int k = 0; k < 6 && base + k < got_win.size(); k++) begin
            r = 1 + k / (W - 2);
            c = 1 + k % (W - 2);
            n_checks++;
            if (got_win[base+k] !== exp_window(W, r, c) || got_row[base+k] !== r || got_col[base+k] !== c) begin
                n_fail++;
                $display("FAIL gap_win%0d: got %h @(%0d,%0d), required %h @(%0d,%0d)", k,
                         got_win[base+k], got_row[base+k], got_col[base+k], exp_window(W, r, c), r, c);
            end
        end
    endtask

    task automatic test_3x3;
        int p = 0;
        int nwin = 0;
        bit acc;
        bit seen_done = 1'b0;
        logic [9*PW-1:0] wv = '0;
        logic [9*PW-1:0] exp9 = {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
        int wr = -1;
        int wc = -1;
        @(posedge clk); #1 b_frame_start = 1'b1;
        @(posedge clk); #1 b_frame_start = 1'b0;
        for (int cyc = 0; cyc < 40 && !seen_done; cyc++) begin
            b_pix_valid = (p < 9);
            b_pix_data  = PW'(p);
            @(negedge clk);
            acc = b_pix_valid && b_pix_ready;
            if (b_win_valid) begin
                nwin++;
                wv = b_window;
                wr = int'(b_win_row);
                wc = int'(b_win_col);
            end
            if (b_frame_done) seen_done = 1'b1;
            @(posedge clk); #1;
            if (acc) p++;
        end
        b_pix_valid = 1'b0;
        n_checks++;
        if (nwin !== 1 || !seen_done) begin
            n_fail++;
            $display("FAIL small_count: got %0d windows done=%b, required 1 window and done", nwin, seen_done);
        end
        n_checks++;
        if (wv !== exp9 || wr !== 1 || wc !== 1) begin
            n_fail++;
            $display("FAIL small_window: got %h @(%0d,%0d), required %h @(1,1)", wv, wr, wc, exp9);
        end
    endtask

    initial begin
        rst = 1'b1; frame_start = 1'b0; pix_valid = 1'b0; pix_data = '0; win_ready = 1'b1;
        b_frame_start = 1'b0; b_pix_valid = 1'b0; b_pix_data = '0; b_win_ready = 1'b1;
        test_reset;
        test_basic;
        test_backpressure;
        test_mid_start;
        test_reset_midframe;
        test_gapped;
        test_3x3;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
